div_seq: RTL
============

Name: div_seq

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath.
- Executes the DIV instruction on the A and B register values: one quotient bit per cycle, restoring algorithm on magnitudes, then sign fix-up.
- The control unit raises div_start and waits for done.
- Remainder feeds the HI register path and quotient the LO register path; division by zero raises div_zero for the control unit's exception sequence.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
div_start  input  1  start request from control unit; sampled only in IDLE
a_in  input  WIDTH  dividend (A register), signed two's complement
b_in  input  WIDTH  divisor (B register), signed two's complement
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle completion pulse
div_zero  output  1  divisor-was-zero flag
hi_out  output  WIDTH  remainder
lo_out  output  WIDTH  quotient

Behaviour:
- Reset (synchronous, while reset=1 at edge): state=IDLE, busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, internal registers cleared. Reset has priority over everything, including mid-operation; an aborted division produces no done pulse.
- States are IDLE, RUN, FIX and DONE.
- IDLE to RUN/DONE: div_start=1 sampled at edge T is accepted.
  - Operands are captured at T; later a_in/b_in changes have no effect.
  - div_zero is cleared at acceptance.
- Zero divisor: if b_in==0 at T, go to DONE at T+1: done=1, div_zero=1, hi_out/lo_out keep previous values, busy stays 0. Then return to IDLE.
- Nonzero divisor:
  - Store |a| and |b| as WIDTH+1-bit unsigned values (so -2^31 is representable), plus sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
  - Load an iteration counter with WIDTH. busy=1 from T+1.
- RUN: one iteration per cycle, for cycles T+1..T+WIDTH.
  - Shift {rem,quo} left by 1.
  - Trial-subtract |b| from rem. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore rem and set the LSB to 0.
  - Decrement the counter; leave RUN when it reaches 0.
- FIX (T+WIDTH+1):
  - lo_out = sign_q ? -quo : quo, truncated to WIDTH bits.
  - hi_out = sign_r ? -rem : rem.
  - The quotient truncates toward zero; the remainder takes the dividend's sign.
- DONE (T+WIDTH+2): done=1 for exactly one cycle, busy=0; next state IDLE. With WIDTH=32, done asserts at T+34.
- div_start is accepted in IDLE only. It is ignored while busy, in FIX and in DONE; there is no queuing. A start held high continuously re-triggers on the first IDLE cycle after DONE.
- Overflow case -2^31 / -1: the quotient wraps to lo_out=0x80000000, hi_out=0, and no flag is raised.
- Output holding:
  - hi_out/lo_out hold their last values until the next completed nonzero division or reset; they are never driven with intermediate values.
  - div_zero holds until the next accepted start or reset.
- Arithmetic: all negation is two's complement modulo 2^WIDTH. |x| is computed in WIDTH+1 bits to avoid overflow.

Test Plan:
- Positive operands: a=100, b=7, start at T -> busy 1 at T+1..T+33; done=1 only at T+34; lo_out=14, hi_out=2, div_zero=0.
- Negative dividend: a=-7 (0xFFFFFFF9), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
- Negative divisor and overflow, back to back:
  - a=7, b=-2 -> lo_out=0xFFFFFFFD, hi_out=1.
  - Then a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Divide by zero: prior result lo=14/hi=2, then a=5, b=0 at T -> done=1 and div_zero=1 at T+1, busy never 1, lo_out=14 and hi_out=2 unchanged. div_zero clears on the next accepted start.
- Ignored start: a=100, b=7, then div_start pulsed at T+5 with a=1, b=1 -> result still lo=14, hi=2 at T+34, with exactly one done pulse.
- Reset mid-operation: reset=1 at T+10 -> next edge busy=0, done=0, div_zero=0, hi_out=0, lo_out=0. No done pulse follows; a new start after reset completes normally in 34 cycles.

Source files
------------

// File: rtl/div_seq.sv
// Sequential signed divider for the multicycle MIPS datapath: restoring division
// on operand magnitudes, one quotient bit per cycle, followed by a sign fix-up step.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic             b_is_zero;

  // Magnitudes are kept as unsigned WIDTH-bit values, which already covers 2^(WIDTH-1).
  logic [WIDTH-1:0] rem, quo, b_abs;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;

  logic [WIDTH-1:0] a_abs_in, b_abs_in;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    b_is_zero = (b_in == '0);
    a_abs_in  = a_in[WIDTH-1] ? -a_in : a_in;
    b_abs_in  = b_in[WIDTH-1] ? -b_in : b_in;
    shifted   = {rem, quo[WIDTH-1]};
    fits      = (shifted >= {1'b0, b_abs});
    // When the trial subtraction fits, the result is below |b| and thus fits WIDTH bits.
    diff      = shifted[WIDTH-1:0] - b_abs;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          accept   = 1'b1;
          state_nx = b_is_zero ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      b_abs    <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            div_zero <= b_is_zero;
            rem      <= '0;
            quo      <= a_abs_in;
            b_abs    <= b_abs_in;
            sign_q   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            sign_r   <= a_in[WIDTH-1];
            cnt      <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (fits) begin
            rem <= diff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          lo_out <= sign_q ? -quo : quo;
          hi_out <= sign_r ? -rem : rem;
        end
        DONE: ;
      endcase
    end
  end

endmodule
